learn_commit: RTL
=================

LEARN_COMMIT -- requirements
Module: learn_commit

Interface
REQ-001 Parameters: MAX_LITS, default 8, maximum learned-clause literals; LEVEL_W, default 8, decision-level width; ADDR_W, default 10, clause-store literal address width; LIT_W fixed at 32, signed DIMACS-style literal.
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- cae_done  in  1  one-cycle pulse from conflict analysis; result valid this cycle.
- cae_learned_valid  in  1  learned clause present.
- cae_learned_len  in  4  literal count.
- cae_learned_clause  in  MAX_LITS x LIT_W  literals; index 0 is the asserting (UIP) literal.
- cae_backtrack_level  in  LEVEL_W  target level.
- cae_unsat  in  1  level-0 conflict.
- wr_valid  out  1  clause-store write request.
- wr_ready  in  1  clause store accepts the write.
- wr_addr  out  ADDR_W  literal address.
- wr_lit  out  LIT_W  literal data.
- wr_last  out  1  final literal of the clause.
- bt_valid  out  1  backtrack request to the trail.
- bt_ready  in  1  trail accepts the request.
- bt_level  out  LEVEL_W  backtrack level.
- asn_valid  out  1  asserting-literal enqueue to propagation.
- asn_ready  in  1  propagation accepts.
- asn_lit  out  LIT_W  asserting literal.
- asn_clause_addr  out  ADDR_W  base address of the reason clause.
- busy  out  1  high in any state other than IDLE.
- unsat  out  1  sticky UNSAT.
- mem_full  out  1  sticky: clause store exhausted.
- err  out  1  sticky: malformed result or result dropped while busy.
- learned_count  out  16  clauses committed, saturating.

Function
REQ-003 FSM states: IDLE, WRITE, BACKTRACK, ASSERT, HALT.
REQ-004 IDLE: on cae_done, capture all cae_* inputs into internal registers in the same edge; the bench may change the inputs on the next cycle.
REQ-005 Capture priority, evaluated in order:
- cae_unsat=1: set unsat, go to HALT.
- cae_learned_valid=0: stay in IDLE; no action.
- len=0 or len>MAX_LITS: set err, stay in IDLE.
- free_ptr+len > 2^ADDR_W, evaluated in ADDR_W+1 bits: set mem_full, go to HALT.
- Otherwise: set base=free_ptr, go to WRITE.
REQ-006 WRITE: present literal idx (from 0) with wr_addr=base+idx and wr_last=(idx==len-1).
- wr_valid stays high, with stable data, until wr_ready.
- Each handshake advances idx.
- The handshake on the last literal sets free_ptr=base+len and goes to BACKTRACK.
REQ-007 BACKTRACK: bt_valid=1, bt_level=captured level, held until bt_ready; then go to ASSERT.
REQ-008 ASSERT: asn_valid=1, asn_lit=literal 0, asn_clause_addr=base, held until asn_ready; then increment learned_count (saturating at 0xFFFF) and return to IDLE.
REQ-009 At most one of wr_valid, bt_valid, asn_valid is high in any cycle; each is registered, with no combinational path from any ready input.
REQ-010 Minimum latency: from the cae_done edge, the first wr_valid is high the next cycle. With all readies tied high, a len-L clause completes (asn handshake) L+2 cycles after capture, and busy drops the following cycle.
REQ-011 A cae_done while busy=1 is ignored and sets err, except in HALT, where it is ignored silently.
REQ-012 HALT is terminal until reset. All valids are 0 and busy is 1.
REQ-013 free_ptr wraps never: mem_full gating is the sole overflow protection. An exact fit (free_ptr+len == 2^ADDR_W) is accepted.
REQ-014 Unused literal slots beyond len are never written.

Reset
REQ-015 reset low asynchronously forces:
- state=IDLE, free_ptr=0, idx=0, learned_count=0.
- unsat, mem_full, err, busy, wr_valid, bt_valid, asn_valid all 0.
- wr_addr, wr_lit, wr_last, bt_level, asn_lit, asn_clause_addr all 0.
REQ-016 A reset asserted mid-handshake aborts the clause with no partial commit to free_ptr; deassertion is synchronous to clk through a 2-flop release.

Verification
REQ-017 len=3 clause {10,-11,12}, level=3, readies high -> writes (0,10),(1,-11),(2,12,last); bt_level=3; asn_lit=10, addr 0; learned_count=1.
REQ-018 A second clause len=2 {-7,4} -> wr_addr 3,4; asn_clause_addr=3. With wr_ready low for 4 cycles on idx 1, data is held stable and no bt_valid occurs early.
REQ-019 cae_unsat=1 at cae_done -> unsat=1 next cycle; no wr/bt/asn activity; subsequent cae_done is ignored and err stays 0.
REQ-020 ADDR_W=3 with free_ptr=6: len=2 is accepted (exact fit); a following len=1 sets mem_full with no write.
REQ-021 len=0 with valid=1 -> err=1, stays IDLE. cae_done during WRITE -> err=1, current clause completes unaffected.
REQ-022 reset pulsed during BACKTRACK -> all outputs 0 and free_ptr=0; a new len=1 clause writes to address 0.

Source files
------------

// File: rtl/learn_commit_if.sv
// Commit-side handshake bundle: clause-store write, trail backtrack request
// and asserting-literal enqueue, each a valid/ready channel.
interface learn_commit_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LEVEL_W = 8
);
  localparam int unsigned LIT_W = 32;

  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [LIT_W-1:0]   wr_lit;
  logic               wr_last;

  logic               bt_valid;
  logic               bt_ready;
  logic [LEVEL_W-1:0] bt_level;

  logic               asn_valid;
  logic               asn_ready;
  logic [LIT_W-1:0]   asn_lit;
  logic [ADDR_W-1:0]  asn_clause_addr;

  modport master (
    output wr_valid, wr_addr, wr_lit, wr_last,
    input  wr_ready,
    output bt_valid, bt_level,
    input  bt_ready,
    output asn_valid, asn_lit, asn_clause_addr,
    input  asn_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_lit, wr_last,
    output wr_ready,
    input  bt_valid, bt_level,
    output bt_ready,
    input  asn_valid, asn_lit, asn_clause_addr,
    output asn_ready
  );
endinterface

// File: rtl/learn_commit.sv
// Learned-clause commit engine: takes a conflict-analysis result, streams the
// clause into the clause store, requests the backtrack, then enqueues the
// asserting literal with its reason-clause address.
module learn_commit #(
  parameter int unsigned MAX_LITS = 8,
  parameter int unsigned LEVEL_W  = 8,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cae_done,
  input  logic                       cae_learned_valid,
  input  logic [3:0]                 cae_learned_len,
  input  logic [MAX_LITS*32-1:0]     cae_learned_clause,
  input  logic [LEVEL_W-1:0]         cae_backtrack_level,
  input  logic                       cae_unsat,
  learn_commit_if.master             commit,
  output logic                       busy,
  output logic                       unsat,
  output logic                       mem_full,
  output logic                       err,
  output logic [15:0]                learned_count
);
  localparam int unsigned LIT_W = 32;

  typedef enum logic [2:0] {IDLE, WRITE, BACKTRACK, ASSERT, HALT} state_t;
  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W+4:0] sum_t;

  localparam sum_t CAPACITY = sum_t'(1) << ADDR_W;

  state_t                  state;
  ptr_t                    free_ptr;
  logic [ADDR_W-1:0]       base;
  logic [3:0]              idx;
  logic [3:0]              len_q;
  logic [LEVEL_W-1:0]      level_q;
  logic [MAX_LITS*LIT_W-1:0] clause_q;

  logic                    wr_valid, wr_last, bt_valid, asn_valid;
  logic [ADDR_W-1:0]       wr_addr, asn_clause_addr;
  logic [LIT_W-1:0]        wr_lit, asn_lit;
  logic [LEVEL_W-1:0]      bt_level;

  logic [1:0]              rst_sync;
  logic                    rst_n;

  logic                    len_bad;
  logic                    no_room;
  logic [3:0]              nxt;

  assign commit.wr_valid        = wr_valid;
  assign commit.wr_addr         = wr_addr;
  assign commit.wr_lit          = wr_lit;
  assign commit.wr_last         = wr_last;
  assign commit.bt_valid        = bt_valid;
  assign commit.bt_level        = bt_level;
  assign commit.asn_valid       = asn_valid;
  assign commit.asn_lit         = asn_lit;
  assign commit.asn_clause_addr = asn_clause_addr;

  // Reset asserts immediately, releases two clocks after the pin rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Capture qualification; the fit test uses extra headroom so it can never wrap.
  always_comb begin
    len_bad = (cae_learned_len == 4'd0) || (32'(cae_learned_len) > MAX_LITS);
    no_room = (sum_t'(free_ptr) + sum_t'(cae_learned_len)) > CAPACITY;
    nxt     = idx + 4'd1;
  end

  // Commit FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      free_ptr        <= '0;
      base            <= '0;
      idx             <= '0;
      len_q           <= '0;
      level_q         <= '0;
      clause_q        <= '0;
      wr_valid        <= 1'b0;
      wr_addr         <= '0;
      wr_lit          <= '0;
      wr_last         <= 1'b0;
      bt_valid        <= 1'b0;
      bt_level        <= '0;
      asn_valid       <= 1'b0;
      asn_lit         <= '0;
      asn_clause_addr <= '0;
      busy            <= 1'b0;
      unsat           <= 1'b0;
      mem_full        <= 1'b0;
      err             <= 1'b0;
      learned_count   <= '0;
    end else begin
      if (cae_done && state != IDLE && state != HALT) err <= 1'b1;
      case (state)
        IDLE: begin
          if (cae_done) begin
            clause_q <= cae_learned_clause;
            len_q    <= cae_learned_len;
            level_q  <= cae_backtrack_level;
            if (cae_unsat) begin
              unsat <= 1'b1;
              busy  <= 1'b1;
              state <= HALT;
            end else if (!cae_learned_valid) begin
              state <= IDLE;
            end else if (len_bad) begin
              err <= 1'b1;
            end else if (no_room) begin
              mem_full <= 1'b1;
              busy     <= 1'b1;
              state    <= HALT;
            end else begin
              base     <= free_ptr[ADDR_W-1:0];
              idx      <= '0;
              wr_valid <= 1'b1;
              wr_addr  <= free_ptr[ADDR_W-1:0];
              wr_lit   <= cae_learned_clause[LIT_W-1:0];
              wr_last  <= (cae_learned_len == 4'd1);
              busy     <= 1'b1;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (wr_ready_q()) begin
            if (wr_last) begin
              wr_valid <= 1'b0;
              free_ptr <= ptr_t'(base) + ptr_t'(len_q);
              bt_valid <= 1'b1;
              bt_level <= level_q;
              state    <= BACKTRACK;
            end else begin
              idx     <= nxt;
              wr_addr <= base + ADDR_W'(nxt);
              wr_lit  <= clause_q[nxt*LIT_W +: LIT_W];
              wr_last <= (nxt == len_q - 4'd1);
            end
          end
        end
        BACKTRACK: begin
          if (commit.bt_ready) begin
            bt_valid        <= 1'b0;
            asn_valid       <= 1'b1;
            asn_lit         <= clause_q[LIT_W-1:0];
            asn_clause_addr <= base;
            state           <= ASSERT;
          end
        end
        ASSERT: begin
          if (commit.asn_ready) begin
            asn_valid <= 1'b0;
            if (learned_count != 16'hFFFF) learned_count <= learned_count + 16'd1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic wr_ready_q();
    return commit.wr_ready;
  endfunction
endmodule
